pipeline_elastic_stage: RTL and testbench
=========================================

PIPELINE_ELASTIC_STAGE -- requirements
Module: pipeline_elastic_stage

Interface
REQ-001 Parameter PAYLOAD_WIDTH, default 160: width of the bundled decode-to-execute fields.
REQ-002 Parameter TAG_WIDTH, default 3: active-list index width.
REQ-003 Parameter DEPTH, default 2: entry count, power of two, legal range 2..8.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream offers an entry.
REQ-007 in_ready  output  1  stage can accept an entry.
REQ-008 in_payload  input  PAYLOAD_WIDTH  upstream fields.
REQ-009 in_tag  input  TAG_WIDTH  active-list index of the offered entry.
REQ-010 out_valid  output  1  head entry present.
REQ-011 out_ready  input  1  downstream takes the head entry.
REQ-012 out_payload  output  PAYLOAD_WIDTH  head payload; all-zero when out_valid=0.
REQ-013 out_tag  output  TAG_WIDTH  head tag; zero when out_valid=0.
REQ-014 flush  input  1  squash every entry and the offered input.
REQ-015 kill_valid  input  1  selective squash request.
REQ-016 kill_tag  input  TAG_WIDTH  entries strictly younger than this tag are squashed.
REQ-017 oldest_tag  input  TAG_WIDTH  active-list head, the age reference.
REQ-018 count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-019 Storage SHALL be an in-order FIFO with head/tail pointers of clog2(DEPTH) bits wrapping modulo DEPTH, plus a separate occupancy counter.
REQ-020 Push occurs when in_valid and in_ready; pop occurs when out_valid and out_ready.
REQ-021 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-022 Latency: an entry pushed at edge N is visible at out_valid after edge N; sustained throughput is 1 entry/cycle when out_ready stays high.
REQ-023 Simultaneous push and pop when full is not possible (in_ready=0); when count is between 0 and DEPTH exclusive, push and pop in the same cycle leave count unchanged.
REQ-024 Age: tag A is younger than tag K iff (A - oldest_tag) mod 2^TAG_WIDTH > (K - oldest_tag) mod 2^TAG_WIDTH.
REQ-025 kill_valid SHALL remove every stored entry younger than kill_tag by retracting the tail, since younger entries form a contiguous tail; the entry tagged kill_tag survives.
REQ-026 In a kill cycle, the offered input SHALL be pushed only if its tag is not younger than kill_tag.
REQ-027 A pop in a kill cycle SHALL complete; the kill applies to the entries that remain.
REQ-028 flush SHALL empty the stage at the next edge (count=0, pointers=0), drop the offered input, and take priority over kill and push; a pop handshake in the same cycle is still considered consumed.
REQ-029 Output state with no push, pop, kill or flush SHALL hold (stall is expressed solely by out_ready=0).

Reset
REQ-030 Asserting rst_n low SHALL clear count, pointers, out_valid, out_payload and out_tag to 0 immediately, including mid-operation; in_ready is 1 during reset.
REQ-031 Storage array contents need no reset; outputs are masked by out_valid.

Structure
REQ-032 The pipeline package SHALL hold TAG_WIDTH default, DEPTH limits and the tag-age comparison function.
REQ-033 A sub-module tag_younger (combinational age compare per REQ-024) SHALL be instantiated per entry plus once for the input.

Verification
REQ-034 Stream 8 entries (tags 0..7) with out_ready=1 -> out_valid follows 1 cycle later, no bubbles, count never exceeds 1.
REQ-035 Hold out_ready=0, push 3 entries, DEPTH=2 -> in_ready drops after 2, count=2, third entry held upstream; release -> order preserved.
REQ-036 Entries with tags 5,6 stored, oldest_tag=4, kill_tag=5 -> only tag 5 remains, count=1.
REQ-037 Wrap: oldest_tag=6, entries 7,0, kill_tag=7, in_tag=1 offered -> entry 0 and input dropped, entry 7 kept.
REQ-038 flush with full stage and in_valid=1 -> next cycle count=0, out_valid=0, out_payload=0.
REQ-039 rst_n asserted mid-stream, asynchronously between edges -> outputs zero immediately; after release the first push appears after one edge.

Source files
------------

// File: rtl/pipeline_elastic_stage_pkg.sv
// Shared constants and tag-age helper for the decode-to-execute stage.
// Ages are measured relative to the active-list head, modulo the tag space.
package pipeline_elastic_stage_pkg;

    localparam int TAG_WIDTH_DEF = 3;
    localparam int DEPTH_MIN     = 2;
    localparam int DEPTH_MAX     = 8;
    localparam int TAG_W_MAX     = 16;

    function automatic logic tag_is_younger(
        input logic [TAG_W_MAX-1:0] tag,
        input logic [TAG_W_MAX-1:0] kill,
        input logic [TAG_W_MAX-1:0] oldest,
        input int unsigned          width
    );
        logic [TAG_W_MAX-1:0] mask;
        logic [TAG_W_MAX-1:0] age_t;
        logic [TAG_W_MAX-1:0] age_k;
        mask  = (TAG_W_MAX'(1) << width) - TAG_W_MAX'(1);
        age_t = (tag - oldest) & mask;
        age_k = (kill - oldest) & mask;
        return age_t > age_k;
    endfunction

endpackage

// File: rtl/pipeline_elastic_stage_tag_younger.sv
// Combinational age compare: is tag_i strictly younger than kill_i,
// with oldest_i as the reference point of the circular tag space.
module tag_younger
    import pipeline_elastic_stage_pkg::*;
#(
    parameter int TAG_WIDTH = TAG_WIDTH_DEF
) (
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic [TAG_WIDTH-1:0] kill_i,
    input  logic [TAG_WIDTH-1:0] oldest_i,
    output logic                 younger_o
);

    assign younger_o = tag_is_younger(
        TAG_W_MAX'(tag_i),
        TAG_W_MAX'(kill_i),
        TAG_W_MAX'(oldest_i),
        TAG_WIDTH
    );

endmodule

// File: rtl/pipeline_elastic_stage.sv
// Elastic decode-to-execute FIFO stage with flush and selective squash.
// Younger entries sit at the tail, so a kill simply retracts the tail.
module pipeline_elastic_stage
    import pipeline_elastic_stage_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 160,
    parameter int TAG_WIDTH     = TAG_WIDTH_DEF,
    parameter int DEPTH         = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [TAG_WIDTH-1:0]     out_tag,
    input  logic                     flush,
    input  logic                     kill_valid,
    input  logic [TAG_WIDTH-1:0]     kill_tag,
    input  logic [TAG_WIDTH-1:0]     oldest_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX ||
        (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two in 2..8");
    end

    logic [PW-1:0]            head_q, head_d;
    logic [PW-1:0]            tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic [PAYLOAD_WIDTH-1:0] pay_q [DEPTH];
    logic [TAG_WIDTH-1:0]     tag_q [DEPTH];

    logic [DEPTH-1:0] ent_yng;
    logic             in_yng;
    logic             pop;
    logic             push;
    logic [CW-1:0]    surv;
    logic [PW-1:0]    wr_ptr;

    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        tag_younger #(
            .TAG_WIDTH(TAG_WIDTH)
        ) u_age (
            .tag_i    (tag_q[g]),
            .kill_i   (kill_tag),
            .oldest_i (oldest_tag),
            .younger_o(ent_yng[g])
        );
    end

    tag_younger #(
        .TAG_WIDTH(TAG_WIDTH)
    ) u_in_age (
        .tag_i    (in_tag),
        .kill_i   (kill_tag),
        .oldest_i (oldest_tag),
        .younger_o(in_yng)
    );

    assign in_ready  = count_q < CW'(DEPTH);
    assign out_valid = count_q != '0;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    assign out_payload = out_valid ? pay_q[head_q] : '0;
    assign out_tag     = out_valid ? tag_q[head_q] : '0;

    // Count survivors after pop and kill, then place the push behind them.
    always_comb begin
        logic [PW-1:0] idx;
        logic          keep;
        idx  = '0;
        keep = 1'b0;
        surv = '0;
        for (int j = 0; j < DEPTH; j++) begin
            idx  = head_q + PW'(j);
            keep = (CW'(j) < count_q) && !(pop && (j == 0));
            if (kill_valid && ent_yng[idx]) begin
                keep = 1'b0;
            end
            if (keep) begin
                surv = surv + CW'(1);
            end
        end

        head_d = pop ? head_q + PW'(1) : head_q;
        wr_ptr = kill_valid ? head_d + surv[PW-1:0] : tail_q;

        push = in_valid & in_ready & ~flush
             & ~(kill_valid & in_yng);

        tail_d  = push ? wr_ptr + PW'(1) : wr_ptr;
        count_d = surv + CW'(push);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are masked by out_valid so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            pay_q[wr_ptr] <= in_payload;
            tag_q[wr_ptr] <= in_tag;
        end
    end

endmodule

// File: tb/tb_pipeline_elastic_stage.sv
// Self-checking bench for pipeline_elastic_stage (DEPTH=2, TAG_WIDTH=3).
// Table rows plus hand sequences; a queue scoreboard tracks stored entries.
module tb_pipeline_elastic_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [159:0] in_payload;
    logic [2:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [159:0] out_payload;
    logic [2:0]   out_tag;
    logic         flush;
    logic         kill_valid;
    logic [2:0]   kill_tag;
    logic [2:0]   oldest_tag;
    logic [1:0]   count;

    pipeline_elastic_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_payload (in_payload),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_payload(out_payload),
        .out_tag    (out_tag),
        .flush      (flush),
        .kill_valid (kill_valid),
        .kill_tag   (kill_tag),
        .oldest_tag (oldest_tag),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   tag;
        logic [159:0] pay;
    } ent_t;

    typedef struct packed {
        logic       iv;
        logic [2:0] tag;
        logic       ordy;
        logic       fl;
        logic       kv;
        logic [2:0] kt;
        logic [2:0] ot;
        logic [1:0] cnt;
    } vec_t;

    ent_t sbq[$];
    vec_t vt[30];
    int   checks = 0;
    int   errors = 0;
    int   seq = 0;

    function automatic vec_t mk(
        input logic iv, input logic [2:0] tag, input logic ordy,
        input logic fl, input logic kv, input logic [2:0] kt,
        input logic [2:0] ot, input logic [1:0] cnt
    );
        vec_t v;
        v.iv = iv; v.tag = tag; v.ordy = ordy; v.fl = fl;
        v.kv = kv; v.kt = kt; v.ot = ot; v.cnt = cnt;
        return v;
    endfunction

    function automatic bit yng(
        input logic [2:0] a, input logic [2:0] k, input logic [2:0] o
    );
        logic [2:0] da;
        logic [2:0] dk;
        da = a - o;
        dk = k - o;
        return da > dk;
    endfunction

    task automatic chk(
        input string nm, input logic [159:0] act, input logic [159:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check and update model, cross posedge.
    task automatic step(
        input logic iv, input logic [2:0] t, input logic ordy,
        input logic fl, input logic kv, input logic [2:0] kt,
        input logic [2:0] ot, input int exp_cnt
    );
        int   sz;
        bit   rdy;
        bit   pop;
        ent_t e;
        seq++;
        e.tag = t;
        e.pay = {5{32'hC0DE0000 + 32'(seq)}};
        in_valid   = iv;
        in_tag     = t;
        in_payload = e.pay;
        out_ready  = ordy;
        flush      = fl;
        kill_valid = kv;
        kill_tag   = kt;
        oldest_tag = ot;
        #1;
        sz  = sbq.size();
        rdy = sz < 2;
        pop = (sz != 0) && ordy;
        if (exp_cnt >= 0) chk("row_count", 160'(count), 160'(exp_cnt));
        chk("count", 160'(count), 160'(sz));
        chk("in_ready", 160'(in_ready), 160'(rdy));
        chk("out_valid", 160'(out_valid), 160'(sz != 0));
        if (sz == 0) begin
            chk("idle_payload", out_payload, 160'(0));
            chk("idle_tag", 160'(out_tag), 160'(0));
        end
        if (pop) begin
            chk("out_tag", 160'(out_tag), 160'(sbq[0].tag));
            chk("out_payload", out_payload, sbq[0].pay);
        end
        if (fl) begin
            sbq.delete();
        end else begin
            if (pop) void'(sbq.pop_front());
            if (kv) begin
                while (sbq.size() > 0 && yng(sbq[$].tag, kt, ot))
                    void'(sbq.pop_back());
            end
            if (iv && rdy && !(kv && yng(t, kt, ot)))
                sbq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(1, 1, 0, 0, 0, 0, 0, 1);
        vt[2]  = mk(1, 2, 0, 0, 0, 0, 0, 2);
        vt[3]  = mk(1, 2, 1, 0, 0, 0, 0, 2);
        vt[4]  = mk(1, 2, 1, 0, 0, 0, 0, 1);
        vt[5]  = mk(0, 0, 1, 0, 0, 0, 0, 1);
        vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        vt[7]  = mk(1, 5, 0, 0, 0, 0, 4, 0);
        vt[8]  = mk(1, 6, 0, 0, 0, 0, 4, 1);
        vt[9]  = mk(0, 0, 0, 0, 1, 5, 4, 2);
        vt[10] = mk(0, 0, 1, 0, 0, 0, 4, 1);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 4, 0);
        vt[12] = mk(1, 7, 0, 0, 0, 0, 6, 0);
        vt[13] = mk(1, 0, 0, 0, 0, 0, 6, 1);
        vt[14] = mk(1, 1, 0, 0, 1, 7, 6, 2);
        vt[15] = mk(0, 0, 0, 0, 0, 0, 6, 1);
        vt[16] = mk(1, 0, 0, 0, 1, 0, 6, 1);
        vt[17] = mk(0, 0, 0, 0, 0, 0, 6, 2);
        vt[18] = mk(0, 0, 1, 0, 0, 0, 6, 2);
        vt[19] = mk(0, 0, 1, 0, 0, 0, 6, 1);
        vt[20] = mk(1, 1, 0, 0, 1, 0, 6, 0);
        vt[21] = mk(0, 0, 0, 0, 0, 0, 6, 0);
        vt[22] = mk(1, 5, 0, 0, 0, 0, 4, 0);
        vt[23] = mk(1, 6, 0, 0, 0, 0, 4, 1);
        vt[24] = mk(0, 0, 1, 0, 1, 5, 4, 2);
        vt[25] = mk(0, 0, 0, 0, 0, 0, 4, 0);
        vt[26] = mk(1, 1, 0, 0, 0, 0, 0, 0);
        vt[27] = mk(1, 2, 0, 0, 0, 0, 0, 1);
        vt[28] = mk(1, 3, 0, 1, 0, 0, 0, 2);
        vt[29] = mk(0, 0, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        in_valid = 0; in_tag = 0; in_payload = '0;
        out_ready = 0; flush = 0; kill_valid = 0;
        kill_tag = 0; oldest_tag = 0;
        #1;
        chk("rst_count", 160'(count), 160'(0));
        chk("rst_in_ready", 160'(in_ready), 160'(1));
        chk("rst_out_valid", 160'(out_valid), 160'(0));
        chk("rst_payload", out_payload, 160'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            step(vt[i].iv, vt[i].tag, vt[i].ordy, vt[i].fl,
                 vt[i].kv, vt[i].kt, vt[i].ot, int'(vt[i].cnt));
        end

        for (int i = 0; i < 8; i++) begin
            step(1, 3'(i), 1, 0, 0, 0, 0, (i == 0) ? 0 : 1);
        end
        step(0, 0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0);

        step(1, 3, 0, 0, 0, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0, 0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 160'(count), 160'(0));
        chk("mid_rst_out_valid", 160'(out_valid), 160'(0));
        chk("mid_rst_payload", out_payload, 160'(0));
        chk("mid_rst_tag", 160'(out_tag), 160'(0));
        chk("mid_rst_in_ready", 160'(in_ready), 160'(1));
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 5, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
